// File: rtl/ahbl_excl_monitor.sv
// Global exclusive-access monitor for a shared AHB-Lite slave.
// One reservation per HMASTER; drives HEXOKAY and an address-phase store-kill flag.
module ahbl_excl_monitor #(
  parameter int N_MASTERS    = 2,
  parameter int W_ADDR       = 32,
  parameter int GRANULE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ahb_hready,
  input  logic [1:0]           ahb_htrans,
  input  logic [W_ADDR-1:0]    ahb_haddr,
  input  logic                 ahb_hwrite,
  input  logic [2:0]           ahb_hsize,
  input  logic                 ahb_hexcl,
  input  logic [7:0]           ahb_hmaster,
  input  logic                 ahb_hresp,
  input  logic                 clear_all,
  output logic                 hexokay,
  output logic                 excl_wr_fail,
  output logic [N_MASTERS-1:0] resv_valid
);

  localparam int WG = W_ADDR - GRANULE_BITS;
  localparam int WM = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [7:0] NM8 = 8'(N_MASTERS);
  localparam logic [2:0] GB3 = 3'(GRANULE_BITS);

  logic [WG-1:0]        resv_addr [N_MASTERS];
  logic [WG-1:0]        granule;
  logic [N_MASTERS-1:0] match;
  logic [N_MASTERS-1:0] m_onehot;
  logic [N_MASTERS-1:0] dph_onehot;
  logic [N_MASTERS-1:0] valid_nxt;

  logic          aphase;
  logic          m_ok;
  logic          size_ok;
  logic          match_m;
  logic          pass;
  logic          excl_rd;
  logic          excl_wr;
  logic          norm_wr;
  logic          set_ok;
  logic          result;
  logic          err_clr;

  logic          dph_valid;
  logic          dph_ok;
  logic          dph_rd;
  logic [WM-1:0] dph_m;

  assign granule = ahb_haddr[W_ADDR-1:GRANULE_BITS];
  assign aphase  = ahb_hready & ahb_htrans[1];
  assign m_ok    = ahb_hmaster < NM8;
  assign size_ok = ahb_hsize <= GB3;

  assign excl_rd = ahb_hexcl & ~ahb_hwrite;
  assign excl_wr = ahb_hexcl & ahb_hwrite;
  assign norm_wr = ~ahb_hexcl & ahb_hwrite;

  always_comb begin
    match      = '0;
    m_onehot   = '0;
    dph_onehot = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      match[k]      = resv_valid[k] & (resv_addr[k] == granule);
      m_onehot[k]   = (ahb_hmaster == 8'(k));
      dph_onehot[k] = (dph_m == WM'(k));
    end
  end

  assign match_m = |(match & m_onehot);
  assign pass    = m_ok & size_ok & match_m;
  assign set_ok  = m_ok & size_ok;

  assign excl_wr_fail = ahb_htrans[1] & excl_wr & ~pass;

  // Error on an exclusive read: drop the reservation on the first error cycle
  assign err_clr = dph_valid & dph_ok & dph_rd & ahb_hresp & ~ahb_hready;

  always_comb begin
    valid_nxt = resv_valid;
    if (clear_all) valid_nxt = '0;
    if (err_clr)   valid_nxt = valid_nxt & ~dph_onehot;
    if (aphase) begin
      unique case (1'b1)
        excl_rd: begin
          if (set_ok) valid_nxt = valid_nxt | m_onehot;
        end
        excl_wr: begin
          valid_nxt = valid_nxt & ~m_onehot;
          if (pass) valid_nxt = valid_nxt & ~match;
        end
        norm_wr: valid_nxt = valid_nxt & ~match;
        default: ;
      endcase
    end
  end

  always_comb begin
    result = 1'b0;
    unique case (1'b1)
      excl_rd: result = set_ok;
      excl_wr: result = pass;
      default: result = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid <= '0;
      for (int k = 0; k < N_MASTERS; k++)
        resv_addr[k] <= '0;
    end else begin
      resv_valid <= valid_nxt;
      for (int k = 0; k < N_MASTERS; k++)
        if (aphase && excl_rd && set_ok && m_onehot[k])
          resv_addr[k] <= granule;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_valid <= 1'b0;
      dph_ok    <= 1'b0;
      dph_rd    <= 1'b0;
      dph_m     <= '0;
    end else if (aphase) begin
      dph_valid <= 1'b1;
      dph_ok    <= result;
      dph_rd    <= excl_rd;
      dph_m     <= ahb_hmaster[WM-1:0];
    end else if (ahb_hready) begin
      dph_valid <= 1'b0;
      dph_ok    <= 1'b0;
      dph_rd    <= 1'b0;
    end
  end

  assign hexokay = dph_valid & dph_ok & ~ahb_hresp;

endmodule
